// File: rtl/grf_pkg.sv
// Shared defaults and helpers for the parametrised 1-write/N-read register file.
// Pure declarations: no logic, no latency, no flow control.
package grf_pkg;

    localparam int DEF_DWIDTH = 32;
    localparam int DEF_AWIDTH = 4;
    localparam int DEF_NRD    = 2;
    localparam int NBYTES     = DEF_DWIDTH / 8;

    // Fixed-width carrier so one helper serves every packed port vector size.
    localparam int VEC_MAX = 256;
    typedef logic [VEC_MAX-1:0] pvec_t;

    function automatic int nbytes_of(input int dw);
        return dw / 8;
    endfunction

    function automatic pvec_t unpack_field(input pvec_t vec, input int k, input int w);
        pvec_t mask;
        mask = (pvec_t'(1) << w) - pvec_t'(1);
        return (vec >> (k * w)) & mask;
    endfunction

    function automatic pvec_t pack_field(input pvec_t vec, input pvec_t field, input int k, input int w);
        pvec_t mask;
        mask = (pvec_t'(1) << w) - pvec_t'(1);
        return (vec & ~(mask << (k * w))) | ((field & mask) << (k * w));
    endfunction

endpackage

// File: rtl/grf_byte_merge.sv
// Byte-lane merge of new write data over the old register word.
// Purely combinational, zero latency, no backpressure.
module grf_byte_merge
    import grf_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic [DWIDTH-1:0]   i_old,
    input  logic [DWIDTH-1:0]   i_din,
    input  logic [DWIDTH/8-1:0] i_wen,
    output logic [DWIDTH-1:0]   o_merged
);

    localparam int NB = nbytes_of(DWIDTH);

    always_comb begin
        o_merged = i_old;
        for (int b = 0; b < NB; b++) begin
            if (i_wen[b]) begin
                o_merged[b*8 +: 8] = i_din[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/grf1wnr_sb.sv
// 1-write/N-read register file with byte merge, write-through bypass and busy scoreboard.
// Reads are combinational; writes/locks land on the next enabled edge; no backpressure.
module grf1wnr_sb
    import grf_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int AWIDTH  = DEF_AWIDTH,
    parameter int NRD     = DEF_NRD,
    parameter int R0_ZERO = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_b,
    input  logic                  i_clk_en,
    input  logic                  i_cs_b,
    input  logic [AWIDTH-1:0]     i_waddr,
    input  logic [DWIDTH/8-1:0]   i_wen,
    input  logic [DWIDTH-1:0]     i_din,
    input  logic                  i_wunlock,
    input  logic                  i_lock,
    input  logic [AWIDTH-1:0]     i_lock_addr,
    input  logic [NRD*AWIDTH-1:0] i_raddr,
    output logic [NRD*DWIDTH-1:0] o_dout,
    output logic [NRD-1:0]        o_busy,
    output logic [2**AWIDTH-1:0]  o_busy_vec,
    output logic                  o_lock_err
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam bit ZR0   = (R0_ZERO != 0);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_lock_err;

    logic              w_wact;
    logic              w_we;
    logic              w_lock;
    logic              w_unlock;
    logic [DWIDTH-1:0] w_old;
    logic [DWIDTH-1:0] w_merged;
    logic [DEPTH-1:0]  w_set;
    logic [DEPTH-1:0]  w_clr;

    assign w_wact   = !i_cs_b && (|i_wen);
    assign w_we     = w_wact && !(ZR0 && (i_waddr == '0));
    assign w_lock   = i_lock && !(ZR0 && (i_lock_addr == '0));
    assign w_unlock = !i_cs_b && i_wunlock;
    assign w_old    = r_mem[i_waddr];

    // One address decode feeds the scoreboard update, lock_err and o_busy masking.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_lock) begin
            w_set = DEPTH'(1) << i_lock_addr;
        end
        if (w_unlock) begin
            w_clr = DEPTH'(1) << i_waddr;
        end
    end

    grf_byte_merge #(
        .DWIDTH   (DWIDTH)
    ) u_merge (
        .i_old    (w_old),
        .i_din    (i_din),
        .i_wen    (i_wen),
        .o_merged (w_merged)
    );

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_mem[r] <= '0;
            end
        end else if (i_clk_en && w_we) begin
            r_mem[i_waddr] <= w_merged;
        end
    end

    // A lock and an unlock on the same register: the lock wins, a new producer was issued.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_busy     <= '0;
            r_lock_err <= 1'b0;
        end else if (i_clk_en) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (w_set[r]) begin
                    r_busy[r] <= 1'b1;
                end else if (w_clr[r]) begin
                    r_busy[r] <= 1'b0;
                end
            end
            r_lock_err <= w_lock && r_busy[i_lock_addr] && !w_clr[i_lock_addr];
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AWIDTH-1:0] w_ra;
        logic              w_zero;
        logic              w_hit;

        assign w_ra   = AWIDTH'(unpack_field(pvec_t'(i_raddr), k, AWIDTH));
        assign w_zero = ZR0 && (w_ra == '0);
        assign w_hit  = w_wact && (i_waddr == w_ra);

        assign o_dout[k*DWIDTH +: DWIDTH] = w_zero ? '0 : (w_hit ? w_merged : r_mem[w_ra]);
        assign o_busy[k] = !w_zero && r_busy[w_ra] && !w_clr[w_ra];
    end

    assign o_busy_vec = r_busy;
    assign o_lock_err = r_lock_err;

endmodule
